// File: rtl/stack_ctrl.sv
// Operand-stack sequencer: push/pop/replace/peek over req/ack onto a single-port sync RAM.
// Optional PEEK (op 11) is enabled by defining STACK_PEEK_EN; otherwise op 11 acks with no effect.
module stack_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic              mem_en,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  localparam logic [1:0]        OP_PUSH    = 2'b00;
  localparam logic [1:0]        OP_POP     = 2'b01;
  localparam logic [1:0]        OP_REPLACE = 2'b10;
  localparam logic [1:0]        OP_PEEK    = 2'b11;
  localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL   = (ADDR_W+1)'(DEPTH);

  state_t              state_r, next_state_s;
  logic [1:0]          op_r;
  logic [ADDR_W:0]     count_r, count_next_s;
  logic [DATA_W-1:0]   rdata_r;
  logic                ack_r, busy_r, empty_r, full_r, ovf_r, unf_r;
  logic                mem_en_r, mem_wren_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                ovf_s, unf_s, mem_en_s, mem_wren_s;
  logic [ADDR_W-1:0]   mem_addr_s, top_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  assign top_addr_s = count_r[ADDR_W-1:0] - ADDR_ONE;

  // Next-state, pointer update and next-cycle RAM command (RAM outputs are registered from these)
  always_comb begin
    next_state_s = state_r;
    count_next_s = count_r;
    ovf_s        = 1'b0;
    unf_s        = 1'b0;
    mem_en_s     = 1'b0;
    mem_wren_s   = 1'b0;
    mem_addr_s   = {ADDR_W{1'b0}};
    mem_wdata_s  = {DATA_W{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (req) begin
          case (op)
            OP_PUSH: begin
              if (full_r) begin
                next_state_s = S_ACK;
                ovf_s        = 1'b1;
              end else begin
                next_state_s = S_WR;
                mem_en_s     = 1'b1;
                mem_wren_s   = 1'b1;
                mem_addr_s   = count_r[ADDR_W-1:0];
                mem_wdata_s  = wdata;
              end
            end
            OP_POP: begin
              if (empty_r) begin
                next_state_s = S_ACK;
                unf_s        = 1'b1;
              end else begin
                next_state_s = S_RD;
                mem_en_s     = 1'b1;
                mem_addr_s   = top_addr_s;
              end
            end
            OP_REPLACE: begin
              if (empty_r) begin
                next_state_s = S_ACK;
                unf_s        = 1'b1;
              end else begin
                next_state_s = S_WR;
                mem_en_s     = 1'b1;
                mem_wren_s   = 1'b1;
                mem_addr_s   = top_addr_s;
                mem_wdata_s  = wdata;
              end
            end
            OP_PEEK: begin
`ifdef STACK_PEEK_EN
              if (empty_r) begin
                next_state_s = S_ACK;
                unf_s        = 1'b1;
              end else begin
                next_state_s = S_RD;
                mem_en_s     = 1'b1;
                mem_addr_s   = top_addr_s;
              end
`else
              next_state_s = S_ACK;
`endif
            end
            default: next_state_s = S_ACK;
          endcase
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WR: begin
        next_state_s = S_ACK;
        if (op_r == OP_PUSH) begin
          count_next_s = count_r + CNT_ONE;
        end else begin
          count_next_s = count_r;
        end
      end
      S_RD: begin
        next_state_s = S_RD_WAIT;
        if (op_r == OP_POP) begin
          count_next_s = count_r - CNT_ONE;
        end else begin
          count_next_s = count_r;
        end
      end
      S_RD_WAIT: next_state_s = S_ACK;
      S_ACK:     next_state_s = S_IDLE;
      default:   next_state_s = S_IDLE;
    endcase
  end

  // State, pointer, status flags and registered RAM/handshake outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= S_IDLE;
      op_r        <= 2'b00;
      count_r     <= {(ADDR_W+1){1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      ack_r       <= 1'b0;
      busy_r      <= 1'b0;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_wren_r  <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= next_state_s;
      count_r     <= count_next_s;
      empty_r     <= (count_next_s == {(ADDR_W+1){1'b0}});
      full_r      <= (count_next_s == CNT_FULL);
      ack_r       <= (next_state_s == S_ACK);
      busy_r      <= (next_state_s != S_IDLE);
      ovf_r       <= ovf_s;
      unf_r       <= unf_s;
      mem_en_r    <= mem_en_s;
      mem_wren_r  <= mem_wren_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      if (state_r == S_IDLE && req) begin
        op_r <= op;
      end
      // RAM data is valid the cycle after RD presented the address
      if (state_r == S_RD_WAIT) begin
        rdata_r <= mem_rdata;
      end
    end
  end

  assign ack           = ack_r;
  assign rdata         = rdata_r;
  assign busy          = busy_r;
  assign count         = count_r;
  assign empty         = empty_r;
  assign full          = full_r;
  assign err_overflow  = ovf_r;
  assign err_underflow = unf_r;
  assign mem_en        = mem_en_r;
  assign mem_wren      = mem_wren_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: RAM model, reference stack, table vectors and corner sequences.
module tb_stack_ctrl;

  logic        clock, reset, req;
  logic [1:0]  op;
  logic [15:0] wdata, rdata, mem_wdata, mem_rdata;
  logic        ack, busy, empty, full, err_overflow, err_underflow, mem_en, mem_wren;
  logic [5:0]  count;
  logic [4:0]  mem_addr;

  stack_ctrl dut (
    .clock(clock), .reset(reset), .req(req), .op(op), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .count(count), .empty(empty), .full(full),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port synchronous RAM with one-cycle read latency
  logic [15:0] ram [32];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      else          mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rdata;
    int          count;
    logic        ovf;
    logic        unf;
    int          memc;
    logic        wr;
    logic [4:0]  addr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        tbl[5];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] ref_mem [32];
  int          ref_count;
  logic [15:0] ref_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] o, input logic [15:0] d, input int lat,
                              input logic [15:0] rd, input int cnt, input logic ov, input logic un,
                              input int mc, input logic w, input logic [4:0] a);
    exp_t e;
    e.op = o; e.wdata = d; e.lat = lat; e.rdata = rd; e.count = cnt;
    e.ovf = ov; e.unf = un; e.memc = mc; e.wr = w; e.addr = a;
    return e;
  endfunction

  // Reference stack: returns the expected outcome of an op and advances the model
  function automatic exp_t predict(input logic [1:0] o, input logic [15:0] d);
    exp_t e;
    e = mk(o, d, 1, 16'h0000, 0, 1'b0, 1'b0, 0, 1'b0, 5'd0);
    case (o)
      2'b00: if (ref_count == 32) e.ovf = 1'b1;
             else begin
               e.lat = 2; e.memc = 1; e.wr = 1'b1; e.addr = 5'(ref_count);
               ref_mem[ref_count] = d; ref_count++;
             end
      2'b01: if (ref_count == 0) e.unf = 1'b1;
             else begin
               e.lat = 3; e.memc = 1; e.addr = 5'(ref_count - 1);
               ref_rdata = ref_mem[ref_count - 1]; ref_count--;
             end
      2'b10: if (ref_count == 0) e.unf = 1'b1;
             else begin
               e.lat = 2; e.memc = 1; e.wr = 1'b1; e.addr = 5'(ref_count - 1);
               ref_mem[ref_count - 1] = d;
             end
      default: begin
`ifdef STACK_PEEK_EN
        if (ref_count == 0) e.unf = 1'b1;
        else begin
          e.lat = 3; e.memc = 1; e.addr = 5'(ref_count - 1);
          ref_rdata = ref_mem[ref_count - 1];
        end
`endif
      end
    endcase
    e.count = ref_count;
    e.rdata = ref_rdata;
    return e;
  endfunction

  task automatic check_reset_state();
    chk("rst_ack", ack, 0);           chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);       chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);       chk("rst_full", full, 0);
    chk("rst_ovf", err_overflow, 0);  chk("rst_unf", err_underflow, 0);
    chk("rst_mem_en", mem_en, 0);     chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state();
    @(negedge clock);
    reset = 1'b0;
    ref_count = 0;
    ref_rdata = 16'h0000;
  endtask

  // Drive one request, watch the RAM port until ack, then score against the queued expectation
  task automatic run_op(input logic [1:0] o, input logic [15:0] d);
    exp_t e;
    int cyc, memc, stray_err;
    logic got, wr_seen;
    logic [4:0] a;
    logic [15:0] wdo;
    @(negedge clock);
    req = 1'b1; op = o; wdata = d;
    cyc = 0; memc = 0; got = 1'b0; wr_seen = 1'b0; a = 5'd0; wdo = 16'h0000; stray_err = 0;
    while (!got && cyc < 10) begin
      @(posedge clock); #1;
      cyc++;
      if (mem_en) begin memc++; wr_seen = mem_wren; a = mem_addr; wdo = mem_wdata; end
      if (ack) got = 1'b1;
      else if (err_overflow || err_underflow) stray_err++;
    end
    req = 1'b0;
    e = sb_q.pop_front();
    chk("ack_seen", got, 1);
    chk("latency", cyc, e.lat);
    chk("rdata", rdata, e.rdata);
    chk("count", count, e.count);
    chk("err_overflow", err_overflow, e.ovf);
    chk("err_underflow", err_underflow, e.unf);
    chk("err_outside_ack", stray_err, 0);
    chk("mem_cycles", memc, e.memc);
    if (e.memc > 0) begin
      chk("mem_wren", wr_seen, e.wr);
      chk("mem_addr", a, e.addr);
      if (e.wr) chk("mem_wdata", wdo, e.wdata);
    end
    @(posedge clock); #1;
    chk("ack_one_cycle", ack, 0);
    chk("idle_busy", busy, 0);
    chk("empty", empty, (e.count == 0));
    chk("full", full, (e.count == 32));
  endtask

  task automatic issue(input logic [1:0] o, input logic [15:0] d);
    sb_q.push_back(predict(o, d));
    run_op(o, d);
  endtask

  initial begin
    exp_t dummy;
    int cyc;
    logic ack_hit;
    reset = 1'b1; req = 1'b0; op = 2'b00; wdata = 16'h0000;
    for (int i = 0; i < 32; i++) begin ram[i] = 16'h0000; ref_mem[i] = 16'h0000; end
    ref_count = 0; ref_rdata = 16'h0000;

    tbl[0] = mk(2'b00, 16'h1234, 2, 16'h0000, 1, 1'b0, 1'b0, 1, 1'b1, 5'd0);
    tbl[1] = mk(2'b00, 16'h00AB, 2, 16'h0000, 2, 1'b0, 1'b0, 1, 1'b1, 5'd1);
    tbl[2] = mk(2'b01, 16'h0000, 3, 16'h00AB, 1, 1'b0, 1'b0, 1, 1'b0, 5'd1);
    tbl[3] = mk(2'b01, 16'h0000, 3, 16'h1234, 0, 1'b0, 1'b0, 1, 1'b0, 5'd0);
    tbl[4] = mk(2'b01, 16'h0000, 1, 16'h1234, 0, 1'b0, 1'b1, 0, 1'b0, 5'd0);

    do_reset();

    for (int i = 0; i < 5; i++) begin
      dummy = predict(tbl[i].op, tbl[i].wdata);
      sb_q.push_back(tbl[i]);
      run_op(tbl[i].op, tbl[i].wdata);
    end

    // Fill to full, then an overflowing push must leave RAM and count alone
    for (int i = 0; i < 32; i++) issue(2'b00, 16'(16'h0100 + 16'(i * 3)));
    issue(2'b00, 16'hFFFF);
    chk("ram31_kept", ram[31], ref_mem[31]);

    do_reset();
    issue(2'b00, 16'h0A01);
    issue(2'b00, 16'h0A02);
    issue(2'b00, 16'h0A03);
    issue(2'b10, 16'h0007);
    issue(2'b01, 16'h0000);

    // Reset asserted while a POP sits in RD_WAIT
    @(negedge clock);
    req = 1'b1; op = 2'b01; wdata = 16'h0000;
    ack_hit = 1'b0;
    for (cyc = 0; cyc < 2; cyc++) begin
      @(posedge clock); #1;
      if (ack) ack_hit = 1'b1;
    end
    req = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    if (ack) ack_hit = 1'b1;
    chk("midrst_no_ack", ack_hit, 0);
    chk("midrst_count", count, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_empty", empty, 1);
    @(negedge clock);
    reset = 1'b0;
    ref_count = 0; ref_rdata = 16'h0000;

    issue(2'b00, 16'h0B01);
    issue(2'b00, 16'h0B02);
    issue(2'b11, 16'h0000);
    issue(2'b01, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
